// File: rtl/alu_ctrl_seq.sv
// Registered ALU-control decode stage at ID/EX. Multi-cycle mult/div are sequenced by
// a latency counter, and HI/LO-dependent instructions are stalled while one is in flight.
module alu_ctrl_seq #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [3:0]       i_ALUOp,
  input  logic [5:0]       i_funct,
  input  logic             i_flush,
  output logic             o_ready,
  output logic             o_valid,
  output logic [3:0]       o_ALUControl,
  output logic             o_illegal,
  output logic             o_md_busy,
  output logic             o_md_op,
  output logic             o_md_start,
  output logic             o_md_done,
  output logic [1:0]       o_dbg_state,
  output logic [CNT_W-1:0] o_dbg_cnt
);

  // Handshake: the stage takes an instruction on a rising edge when i_valid && o_ready
  // && !i_flush. o_ready only drops for a HI/LO-op offered while mult/div is busy.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [3:0]       r_code;
  logic             r_illegal;
  logic             r_md_op;
  logic             r_md_start;

  logic [3:0]       w_code;
  logic             w_illegal;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_hilo;
  logic             w_busy;
  logic             w_ready;
  logic             w_accept;
  logic             w_md_launch;
  logic             w_done;

  always_comb begin
    w_code    = 4'b1111;
    w_illegal = 1'b1;
    w_is_mul  = 1'b0;
    w_is_div  = 1'b0;
    w_hilo    = 1'b0;
    case (i_ALUOp)
      4'b0000: begin w_code = 4'b0000; w_illegal = 1'b0; end
      4'b0001: begin w_code = 4'b0001; w_illegal = 1'b0; end
      4'b0011: begin w_code = 4'b0010; w_illegal = 1'b0; end
      4'b0100: begin w_code = 4'b0011; w_illegal = 1'b0; end
      4'b0101: begin w_code = 4'b1000; w_illegal = 1'b0; end
      4'b0010: begin
        w_illegal = 1'b0;
        case (i_funct)
          6'b100000: w_code = 4'b0000;
          6'b100010: w_code = 4'b0001;
          6'b100100: w_code = 4'b0010;
          6'b100101: w_code = 4'b0011;
          6'b100111: w_code = 4'b1001;
          6'b101010: w_code = 4'b1000;
          6'b000000: w_code = 4'b0100;
          6'b000010: w_code = 4'b0101;
          6'b000011: w_code = 4'b0110;
          6'b100110: w_code = 4'b0111;
          6'b011000: begin w_code = 4'b1100; w_is_mul = 1'b1; w_hilo = 1'b1; end
          6'b011010: begin w_code = 4'b1101; w_is_div = 1'b1; w_hilo = 1'b1; end
          6'b010000: begin w_code = 4'b1010; w_hilo = 1'b1; end
          6'b010010: begin w_code = 4'b1011; w_hilo = 1'b1; end
          default:   begin w_code = 4'b1111; w_illegal = 1'b1; end
        endcase
      end
      default: begin w_code = 4'b1111; w_illegal = 1'b1; end
    endcase
  end

  assign w_busy      = (r_state != S_IDLE);
  assign w_ready     = !(w_busy && i_valid && w_hilo);
  assign w_accept    = i_valid && w_ready && !i_flush;
  // Stalling keeps every accepted mult/div in IDLE, so launch never overlaps a busy window.
  assign w_md_launch = (r_state == S_IDLE) && w_accept && (w_is_mul || w_is_div);
  assign w_done      = w_busy && (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_md_launch && w_is_mul) begin
          w_next = S_MUL;
        end else if (w_md_launch && w_is_div) begin
          w_next = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == '0) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_md_op    <= 1'b0;
      r_md_start <= 1'b0;
    end else begin
      r_md_start <= w_md_launch;
      if (w_md_launch) begin
        r_cnt   <= w_is_div ? DIV_LOAD : MUL_LOAD;
        r_md_op <= w_is_div;
      end else if (w_busy && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_code    <= 4'b0000;
      r_illegal <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_code    <= w_code;
        r_illegal <= w_illegal;
      end
    end
  end

  assign o_ready      = w_ready;
  assign o_valid      = r_valid;
  assign o_ALUControl = r_code;
  assign o_illegal    = r_illegal;
  assign o_md_busy    = w_busy;
  assign o_md_op      = r_md_op;
  assign o_md_start   = r_md_start;
  assign o_md_done    = w_done;
  assign o_dbg_state  = r_state;
  assign o_dbg_cnt    = r_cnt;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Bench for alu_ctrl_seq: default instance (MUL=4, DIV=32) plus a MUL_CYCLES=1 instance.
// Decode results go through an expected queue; sequencing is checked cycle by cycle.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_op;
  logic [5:0] in_fn;
  logic       in_flush;

  logic       a_ready, a_valid, a_ill, a_busy, a_op, a_start, a_done;
  logic [3:0] a_alu;
  logic [1:0] a_state;
  logic [5:0] a_cnt;
  logic       b_ready, b_valid, b_ill, b_busy, b_op, b_start, b_done;
  logic [3:0] b_alu;
  logic [1:0] b_state;
  logic [5:0] b_cnt;

  logic       sel;
  logic       obs_ready, obs_valid, obs_ill, obs_busy, obs_op, obs_start, obs_done;
  logic [3:0] obs_alu;
  logic [1:0] obs_state;
  logic [5:0] obs_cnt;

  logic [4:0] exp_q[$];
  logic       pend;
  int         n_tests;
  int         n_fail;

  localparam logic [3:0] OP_R    = 4'b0010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  alu_ctrl_seq #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_ALUOp(in_op), .i_funct(in_fn),
    .i_flush(in_flush), .o_ready(a_ready), .o_valid(a_valid), .o_ALUControl(a_alu),
    .o_illegal(a_ill), .o_md_busy(a_busy), .o_md_op(a_op), .o_md_start(a_start),
    .o_md_done(a_done), .o_dbg_state(a_state), .o_dbg_cnt(a_cnt)
  );

  alu_ctrl_seq #(.MUL_CYCLES(1), .DIV_CYCLES(3), .CNT_W(6)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_ALUOp(in_op), .i_funct(in_fn),
    .i_flush(in_flush), .o_ready(b_ready), .o_valid(b_valid), .o_ALUControl(b_alu),
    .o_illegal(b_ill), .o_md_busy(b_busy), .o_md_op(b_op), .o_md_start(b_start),
    .o_md_done(b_done), .o_dbg_state(b_state), .o_dbg_cnt(b_cnt)
  );

  assign obs_ready = sel ? b_ready : a_ready;
  assign obs_valid = sel ? b_valid : a_valid;
  assign obs_alu   = sel ? b_alu   : a_alu;
  assign obs_ill   = sel ? b_ill   : a_ill;
  assign obs_busy  = sel ? b_busy  : a_busy;
  assign obs_op    = sel ? b_op    : a_op;
  assign obs_start = sel ? b_start : a_start;
  assign obs_done  = sel ? b_done  : a_done;
  assign obs_state = sel ? b_state : a_state;
  assign obs_cnt   = sel ? b_cnt   : a_cnt;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ref_decode(input logic [3:0] op, input logic [5:0] fn);
    logic [4:0] r;
    r = {4'b1111, 1'b1};
    case (op)
      4'b0000: r = {4'b0000, 1'b0};
      4'b0001: r = {4'b0001, 1'b0};
      4'b0011: r = {4'b0010, 1'b0};
      4'b0100: r = {4'b0011, 1'b0};
      4'b0101: r = {4'b1000, 1'b0};
      4'b0010: begin
        case (fn)
          6'b100000: r = {4'b0000, 1'b0};
          6'b100010: r = {4'b0001, 1'b0};
          6'b100100: r = {4'b0010, 1'b0};
          6'b100101: r = {4'b0011, 1'b0};
          6'b100111: r = {4'b1001, 1'b0};
          6'b101010: r = {4'b1000, 1'b0};
          6'b000000: r = {4'b0100, 1'b0};
          6'b000010: r = {4'b0101, 1'b0};
          6'b000011: r = {4'b0110, 1'b0};
          6'b100110: r = {4'b0111, 1'b0};
          6'b011000: r = {4'b1100, 1'b0};
          6'b011010: r = {4'b1101, 1'b0};
          6'b010000: r = {4'b1010, 1'b0};
          6'b010010: r = {4'b1011, 1'b0};
          default:   r = {4'b1111, 1'b1};
        endcase
      end
      default: r = {4'b1111, 1'b1};
    endcase
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver: one call = one cycle; checks the result of the previous cycle, then drives
  task automatic step(input logic v, input logic [3:0] op, input logic [5:0] fn,
                      input logic fl);
    logic [4:0] e;
    @(negedge clk);
    check_eq("o_valid", {31'd0, obs_valid}, {31'd0, pend});
    if (pend) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("o_ALUControl", {28'd0, obs_alu}, {28'd0, e[4:1]});
        check_eq("o_illegal", {31'd0, obs_ill}, {31'd0, e[0]});
      end else begin
        check_eq("scoreboard_empty", 32'd1, 32'd0);
      end
    end
    in_valid = v;
    in_op    = op;
    in_fn    = fn;
    in_flush = fl;
    #1;
    pend = v && obs_ready && !fl;
    if (pend) exp_q.push_back(ref_decode(op, fn));
  endtask

  task automatic idle();
    step(1'b0, 4'b0000, 6'b000000, 1'b0);
  endtask

  task automatic check_md(input string tag, input logic busy, input logic start,
                          input logic done, input logic [1:0] st);
    check_eq({tag, "_busy"},  {31'd0, obs_busy},  {31'd0, busy});
    check_eq({tag, "_start"}, {31'd0, obs_start}, {31'd0, start});
    check_eq({tag, "_done"},  {31'd0, obs_done},  {31'd0, done});
    check_eq({tag, "_state"}, {30'd0, obs_state}, {30'd0, st});
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_op    = 4'b0000;
    in_fn    = 6'b000000;
    in_flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", {31'd0, obs_valid}, 32'd0);
    check_eq("rst_alu", {28'd0, obs_alu}, 32'd0);
    check_eq("rst_illegal", {31'd0, obs_ill}, 32'd0);
    check_eq("rst_md_op", {31'd0, obs_op}, 32'd0);
    check_eq("rst_ready", {31'd0, obs_ready}, 32'd1);
    check_eq("rst_cnt", {26'd0, obs_cnt}, 32'd0);
    check_md("rst", 1'b0, 1'b0, 1'b0, 2'd0);
    rst  = 1'b0;
    pend = 1'b0;
    exp_q.delete();
  endtask

  logic [3:0] t_op[17];
  logic [5:0] t_fn[17];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pend    = 1'b0;
    sel     = 1'b0;
    t_op[0] = 4'b0000; t_fn[0] = $urandom_range(0, 63);
    t_op[1] = 4'b0001; t_fn[1] = $urandom_range(0, 63);
    t_op[2] = 4'b0011; t_fn[2] = $urandom_range(0, 63);
    t_op[3] = 4'b0100; t_fn[3] = $urandom_range(0, 63);
    t_op[4] = 4'b0101; t_fn[4] = $urandom_range(0, 63);
    t_fn[5]  = 6'b100000; t_fn[6]  = 6'b100010; t_fn[7]  = 6'b100100;
    t_fn[8]  = 6'b100101; t_fn[9]  = 6'b100111; t_fn[10] = 6'b101010;
    t_fn[11] = 6'b000000; t_fn[12] = 6'b000010; t_fn[13] = 6'b000011;
    t_fn[14] = 6'b100110; t_fn[15] = 6'b010000; t_fn[16] = 6'b010010;
    for (int i = 5; i < 17; i++) t_op[i] = OP_R;

    do_reset();

    // decode table, one instruction per cycle
    for (int i = 0; i < 17; i++) begin
      step(1'b1, t_op[i], t_fn[i], 1'b0);
      check_eq("tbl_ready", {31'd0, obs_ready}, 32'd1);
    end
    // undefined encodings
    step(1'b1, OP_R, 6'b111111, 1'b0);
    step(1'b1, 4'b0111, 6'b100000, 1'b0);
    step(1'b1, OP_R, 6'b000001, 1'b0);
    idle();
    check_eq("illegal_seen", {31'd0, obs_ill}, 32'd1);
    idle();

    // mult with an unstalled add in busy cycle 2
    step(1'b1, OP_R, F_MULT, 1'b0);
    check_eq("mul_c0_ready", {31'd0, obs_ready}, 32'd1);
    idle();
    check_md("mul_c1", 1'b1, 1'b1, 1'b0, 2'd1);
    check_eq("mul_c1_op", {31'd0, obs_op}, 32'd0);
    check_eq("mul_c1_cnt", {26'd0, obs_cnt}, 32'd3);
    step(1'b1, OP_R, F_ADD, 1'b0);
    check_eq("mul_c2_add_ready", {31'd0, obs_ready}, 32'd1);
    check_md("mul_c2", 1'b1, 1'b0, 1'b0, 2'd1);
    idle();
    idle();
    check_md("mul_c4", 1'b1, 1'b0, 1'b1, 2'd1);
    idle();
    check_md("mul_c5", 1'b0, 1'b0, 1'b0, 2'd0);

    // mult with mflo stalled from cycle 2 until cycle 5
    step(1'b1, OP_R, F_MULT, 1'b0);
    idle();
    for (int c = 2; c <= 4; c++) begin
      step(1'b1, OP_R, F_MFLO, 1'b0);
      check_eq("mflo_stall_ready", {31'd0, obs_ready}, 32'd0);
    end
    check_eq("mflo_c4_done", {31'd0, obs_done}, 32'd1);
    step(1'b1, OP_R, F_MFLO, 1'b0);
    check_eq("mflo_c5_ready", {31'd0, obs_ready}, 32'd1);
    idle();
    idle();

    // flush while busy, then a mult offered in the done cycle
    step(1'b1, OP_R, F_MULT, 1'b0);
    step(1'b1, OP_R, F_ADD, 1'b1);
    check_eq("fl_c1_cnt", {26'd0, obs_cnt}, 32'd3);
    step(1'b0, 4'b0000, 6'b000000, 1'b1);
    check_eq("fl_c2_cnt", {26'd0, obs_cnt}, 32'd2);
    check_eq("fl_hold_alu", {28'd0, obs_alu}, 32'hC);
    idle();
    step(1'b1, OP_R, F_MULT, 1'b0);
    check_eq("done_cyc_ready", {31'd0, obs_ready}, 32'd0);
    check_md("done_cyc", 1'b1, 1'b0, 1'b1, 2'd1);
    step(1'b1, OP_R, F_MULT, 1'b0);
    check_eq("after_done_ready", {31'd0, obs_ready}, 32'd1);
    idle();
    check_md("relaunch", 1'b1, 1'b1, 1'b0, 2'd1);
    check_eq("relaunch_cnt", {26'd0, obs_cnt}, 32'd3);
    repeat (4) idle();
    check_md("relaunch_end", 1'b0, 1'b0, 1'b0, 2'd0);

    // flush with mult offered in IDLE
    step(1'b1, OP_R, F_MULT, 1'b1);
    check_eq("idle_flush_ready", {31'd0, obs_ready}, 32'd1);
    idle();
    check_md("idle_flush", 1'b0, 1'b0, 1'b0, 2'd0);

    // div, then reset at busy cycle 10
    step(1'b1, OP_R, F_DIV, 1'b0);
    idle();
    check_md("div_c1", 1'b1, 1'b1, 1'b0, 2'd2);
    check_eq("div_c1_op", {31'd0, obs_op}, 32'd1);
    check_eq("div_c1_cnt", {26'd0, obs_cnt}, 32'd31);
    repeat (9) idle();
    check_eq("div_c10_cnt", {26'd0, obs_cnt}, 32'd22);
    rst = 1'b1;
    #1;
    check_md("div_rst", 1'b0, 1'b0, 1'b0, 2'd0);
    check_eq("div_rst_cnt", {26'd0, obs_cnt}, 32'd0);
    @(negedge clk);
    check_eq("div_rst_nodone", {31'd0, obs_done}, 32'd0);
    rst  = 1'b0;
    pend = 1'b0;
    exp_q.delete();
    step(1'b1, OP_R, F_DIV, 1'b0);
    check_eq("div_again_ready", {31'd0, obs_ready}, 32'd1);
    idle();
    check_md("div_again", 1'b1, 1'b1, 1'b0, 2'd2);

    // MUL_CYCLES=1 instance: back-to-back mult
    sel = 1'b1;
    do_reset();
    step(1'b1, OP_R, F_MULT, 1'b0);
    step(1'b1, OP_R, F_MULT, 1'b0);
    check_eq("m1_second_ready", {31'd0, obs_ready}, 32'd0);
    check_md("m1_c1", 1'b1, 1'b1, 1'b1, 2'd1);
    step(1'b1, OP_R, F_MULT, 1'b0);
    check_eq("m1_c2_ready", {31'd0, obs_ready}, 32'd1);
    check_md("m1_c2", 1'b0, 1'b0, 1'b0, 2'd0);
    idle();
    check_md("m1_c3", 1'b1, 1'b1, 1'b1, 2'd1);
    idle();
    check_md("m1_c4", 1'b0, 1'b0, 1'b0, 2'd0);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
